// File: rtl/ahb_sram_slave.sv
// AHB-Lite responder in front of a word-organised SRAM. It adds programmable
// wait states, byte/half/word lane writes, write-to-read forwarding and the
// two-cycle ERROR response.
module ahb_sram_slave #(
  parameter int unsigned AW          = 8,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        hclk,
  input  logic        hreset,
  input  logic        hsel_i,
  input  logic [31:0] haddr_i,
  input  logic [1:0]  htrans_i,
  input  logic        hwrite_i,
  input  logic [2:0]  hsize_i,
  input  logic [31:0] hwdata_i,
  input  logic        hready_i,
  output logic [31:0] hrdata_o,
  output logic        hreadyout_o,
  output logic        hresp_o
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;

  localparam logic [3:0] WS       = 4'(WAIT_STATES);
  localparam bit         HAS_WAIT = (WAIT_STATES != 0);

  state_t         state, state_nxt;
  logic [3:0]     wcnt;
  logic           dp_valid, dp_write;
  logic [AW-1:0]  dp_addr;
  logic [3:0]     dp_mask;
  logic [31:0]    mem [2**AW];

  logic           accept, in_region, size_ok, aligned, legal, acc_ok;
  logic [AW-1:0]  acc_word, rd_word;
  logic [3:0]     acc_mask;
  logic           wr_en, rd_load;
  logic [31:0]    rd_merged;
  logic           unused_htrans;

  // BUSY and IDLE share htrans[1]=0, so only that bit decides a transfer.
  assign unused_htrans = htrans_i[0];

  // ---------------------------------------------------------------------------
  // Address-phase decode and legality
  // ---------------------------------------------------------------------------
  assign accept    = hsel_i & hready_i & htrans_i[1];
  assign in_region = (haddr_i[31:AW+2] == BASE_ADDR[31:AW+2]);
  assign size_ok   = (hsize_i <= 3'b010);
  assign legal     = in_region & size_ok & aligned;
  assign acc_ok    = accept & legal;
  assign acc_word  = haddr_i[AW+1:2];

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    aligned  = 1'b1;
    acc_mask = 4'b1111;
    case (hsize_i)
      3'b000: acc_mask = 4'b0001 << haddr_i[1:0];
      3'b001: begin
        aligned  = ~haddr_i[0];
        acc_mask = haddr_i[1] ? 4'b1100 : 4'b0011;
      end
      3'b010:  aligned = (haddr_i[1:0] == 2'b00);
      default: acc_mask = 4'b1111;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: state register / next state / outputs
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge hclk) begin
    if (hreset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_ERR2: begin
        if (!accept)     state_nxt = S_IDLE;
        else if (!legal) state_nxt = S_ERR1;
        else             state_nxt = HAS_WAIT ? S_WAIT : S_IDLE;
      end
      S_WAIT:  if (wcnt == 4'd1) state_nxt = S_IDLE;
      S_ERR1:  state_nxt = S_ERR2;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    hreadyout_o = ~((state == S_WAIT) || (state == S_ERR1));
    hresp_o     = (state == S_ERR1) || (state == S_ERR2);
  end

  // ---------------------------------------------------------------------------
  // Wait counter and latched data-phase context
  // ---------------------------------------------------------------------------
  always_ff @(posedge hclk) begin
    if (hreset)                wcnt <= 4'd0;
    else if (acc_ok)           wcnt <= WS;
    else if (state == S_WAIT)  wcnt <= wcnt - 4'd1;
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_addr  <= '0;
      dp_mask  <= 4'b0000;
    end else if (accept) begin
      dp_valid <= legal;
      dp_write <= hwrite_i;
      dp_addr  <= acc_word;
      dp_mask  <= acc_mask;
    end else if (hreadyout_o) begin
      dp_valid <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // SRAM write, read with forwarding of a write completing on the same edge
  // ---------------------------------------------------------------------------
  assign wr_en = dp_valid & dp_write & hreadyout_o & ~hreset;

  // NOTE: the SRAM array has no reset; only control state is cleared.
  always_ff @(posedge hclk) begin
    for (int b = 0; b < 4; b++) begin
      if (wr_en && dp_mask[b]) mem[dp_addr][8*b +: 8] <= hwdata_i[8*b +: 8];
    end
  end

  // With waits the word is fetched on the last WAIT edge; otherwise at accept.
  assign rd_word = (state == S_WAIT) ? dp_addr : acc_word;
  assign rd_load = HAS_WAIT ? ((state == S_WAIT) && (wcnt == 4'd1) && !dp_write)
                            : (acc_ok && !hwrite_i);

  always_comb begin
    rd_merged = mem[rd_word];
    for (int b = 0; b < 4; b++) begin
      if (wr_en && (dp_addr == rd_word) && dp_mask[b])
        rd_merged[8*b +: 8] = hwdata_i[8*b +: 8];
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset)       hrdata_o <= 32'h0;
    else if (rd_load) hrdata_o <= rd_merged;
  end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: one zero-wait and one three-wait instance, driven
// by a pipelined master task and checked by a completion-ordered scoreboard.
module tb_ahb_sram_slave;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    bit          err;
  } xfer_t;

  typedef struct {
    int          dut;
    bit          rd;
    logic [31:0] data;
    bit          resp;
    int          waits;
  } exp_t;

  logic        hclk = 1'b0;
  logic        hreset;
  logic        hsel      [2];
  logic [31:0] haddr     [2];
  logic [1:0]  htrans    [2];
  logic        hwrite    [2];
  logic [2:0]  hsize     [2];
  logic [31:0] hwdata    [2];
  logic [31:0] hrdata    [2];
  logic        hreadyout [2];
  logic        hresp     [2];

  xfer_t       seq_q[$];
  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [31:0] mdl [int];
  bit          pend [2];
  int          wc   [2];
  int          errors = 0;
  int          checks = 0;

  always #5 hclk = ~hclk;

  ahb_sram_slave #(.AW(8), .BASE_ADDR(32'h0), .WAIT_STATES(0)) u_ws0 (
    .hclk(hclk), .hreset(hreset), .hsel_i(hsel[0]), .haddr_i(haddr[0]),
    .htrans_i(htrans[0]), .hwrite_i(hwrite[0]), .hsize_i(hsize[0]),
    .hwdata_i(hwdata[0]), .hready_i(hreadyout[0]), .hrdata_o(hrdata[0]),
    .hreadyout_o(hreadyout[0]), .hresp_o(hresp[0])
  );

  ahb_sram_slave #(.AW(8), .BASE_ADDR(32'h0), .WAIT_STATES(3)) u_ws3 (
    .hclk(hclk), .hreset(hreset), .hsel_i(hsel[1]), .haddr_i(haddr[1]),
    .htrans_i(htrans[1]), .hwrite_i(hwrite[1]), .hsize_i(hsize[1]),
    .hwdata_i(hwdata[1]), .hready_i(hreadyout[1]), .hrdata_o(hrdata[1]),
    .hreadyout_o(hreadyout[1]), .hresp_o(hresp[1])
  );

  function automatic logic [3:0] lanes(input logic [31:0] a, input logic [2:0] s);
    case (s)
      3'b000:  return 4'b0001 << a[1:0];
      3'b001:  return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  task automatic add(input bit wr, input logic [31:0] addr, input logic [2:0] size,
                     input logic [31:0] wdata, input bit err);
    xfer_t x;
    x.wr = wr; x.addr = addr; x.size = size; x.wdata = wdata; x.err = err;
    seq_q.push_back(x);
  endtask

  // Pipelined master: the next address phase overlaps the current data phase.
  task automatic run_seq(input int d);
    xfer_t       x;
    exp_t        e;
    bit          r;
    int          guard;
    int          key;
    logic [31:0] m;
    logic [3:0]  ln;
    @(posedge hclk); #1;
    while (seq_q.size() > 0) begin
      x = seq_q.pop_front();
      hsel[d] = 1'b1; haddr[d] = x.addr; htrans[d] = 2'b10;
      hwrite[d] = x.wr; hsize[d] = x.size;
      key = d * 1000000 + int'(x.addr[11:2]);
      e.dut = d; e.rd = !x.wr; e.data = 32'h0;
      e.resp = x.err; e.waits = x.err ? 1 : ws_of(d);
      if (!x.err && x.wr) begin
        m  = mdl.exists(key) ? mdl[key] : 32'hxxxx_xxxx;
        ln = lanes(x.addr, x.size);
        for (int b = 0; b < 4; b++) if (ln[b]) m[8*b +: 8] = x.wdata[8*b +: 8];
        mdl[key] = m;
      end else if (!x.err) begin
        e.data = mdl[key];
      end
      exp_q.push_back(e);
      guard = 0;
      do begin
        @(negedge hclk); r = hreadyout[d];
        @(posedge hclk); #1; guard++;
      end while (!r && guard < 40);
      if (!r) begin
        checks++; errors++;
        $display("FAIL accept_timeout dut=%0d addr=%h", d, x.addr);
      end
      hwdata[d] = x.wdata;
    end
    hsel[d] = 1'b0; htrans[d] = 2'b00;
    guard = 0;
    while (exp_q.size() > 0 && guard < 40) begin
      @(negedge hclk); guard++;
    end
    @(negedge hclk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain dut=%0d pending=%0d required=0", d, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Completion monitor: counts stalled cycles and compares the final cycle.
  always @(negedge hclk) begin
    for (int d = 0; d < 2; d++) begin
      if (hreset) begin
        pend[d] = 1'b0; wc[d] = 0;
      end else begin
        if (pend[d]) begin
          if (!hreadyout[d]) wc[d]++;
          else begin
            if (exp_q.size() == 0 || exp_q[0].dut != d) begin
              checks++; errors++;
              $display("FAIL unexpected_completion dut=%0d", d);
            end else begin
              mon_e = exp_q.pop_front();
              checks++;
              if (hresp[d] !== mon_e.resp) begin
                errors++;
                $display("FAIL hresp dut=%0d got=%b exp=%b", d, hresp[d], mon_e.resp);
              end
              checks++;
              if (wc[d] != mon_e.waits) begin
                errors++;
                $display("FAIL wait_cycles dut=%0d got=%0d exp=%0d", d, wc[d], mon_e.waits);
              end
              if (mon_e.rd && !mon_e.resp) begin
                checks++;
                if (hrdata[d] !== mon_e.data) begin
                  errors++;
                  $display("FAIL hrdata dut=%0d got=%h exp=%h", d, hrdata[d], mon_e.data);
                end
              end
            end
            wc[d] = 0;
          end
        end
        if (hreadyout[d]) pend[d] = hsel[d] && htrans[d][1];
      end
    end
    if (hreset) exp_q.delete();
  end

  task automatic test_reset();
    hreset = 1'b1;
    repeat (3) @(posedge hclk);
    #1 hreset = 1'b0;
    @(negedge hclk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (hreadyout[d] !== 1'b1) begin
        errors++; $display("FAIL reset_hreadyout dut=%0d got=%b exp=1", d, hreadyout[d]);
      end
      checks++;
      if (hresp[d] !== 1'b0) begin
        errors++; $display("FAIL reset_hresp dut=%0d got=%b exp=0", d, hresp[d]);
      end
      checks++;
      if (hrdata[d] !== 32'h0) begin
        errors++; $display("FAIL reset_hrdata dut=%0d got=%h exp=0", d, hrdata[d]);
      end
    end
  endtask

  task automatic test_word_rw();
    add(1, 32'h10, 3'b010, 32'hDEAD_BEEF, 0);
    run_seq(0);
    add(0, 32'h10, 3'b010, 32'h0, 0);
    run_seq(0);
  endtask

  task automatic test_lanes();
    add(1, 32'h20, 3'b000, 32'hAAAA_AA11, 0);
    add(1, 32'h21, 3'b000, 32'hBBBB_22BB, 0);
    add(1, 32'h22, 3'b001, 32'h4433_CCCC, 0);
    run_seq(0);
    add(0, 32'h20, 3'b010, 32'h0, 0);
    run_seq(0);
  endtask

  task automatic test_wait_states();
    add(1, 32'h30, 3'b010, 32'hCAFE_F00D, 0);
    add(1, 32'h34, 3'b010, 32'h0123_4567, 0);
    add(0, 32'h30, 3'b010, 32'h0, 0);
    add(0, 32'h34, 3'b010, 32'h0, 0);
    add(0, 32'h800, 3'b010, 32'h0, 1);
    add(0, 32'h34, 3'b010, 32'h0, 0);
    run_seq(1);
  endtask

  task automatic test_errors();
    add(1, 32'h00, 3'b010, 32'h1234_5678, 0);
    run_seq(0);
    add(1, 32'h02, 3'b010, 32'hFFFF_FFFF, 1);
    add(1, 32'h00, 3'b011, 32'hFFFF_FFFF, 1);
    add(1, 32'h400, 3'b010, 32'hFFFF_FFFF, 1);
    add(1, 32'h01, 3'b001, 32'hFFFF_FFFF, 1);
    add(0, 32'h00, 3'b010, 32'h0, 0);
    run_seq(0);
  endtask

  task automatic test_back_to_back();
    add(1, 32'h40, 3'b010, 32'hA5A5_A5A5, 0);
    add(0, 32'h40, 3'b010, 32'h0, 0);
    add(1, 32'h44, 3'b000, 32'h0000_0077, 0);
    add(1, 32'h45, 3'b000, 32'h0000_6600, 0);
    add(1, 32'h46, 3'b001, 32'h5544_0000, 0);
    add(0, 32'h44, 3'b010, 32'h0, 0);
    run_seq(0);
  endtask

  task automatic test_reset_in_wait();
    add(1, 32'h80, 3'b010, 32'h0BAD_F00D, 0);
    run_seq(1);
    @(posedge hclk); #1;
    hsel[1] = 1'b1; haddr[1] = 32'h80; htrans[1] = 2'b10;
    hwrite[1] = 1'b1; hsize[1] = 3'b010;
    @(posedge hclk); #1;
    hsel[1] = 1'b0; htrans[1] = 2'b00; hwdata[1] = 32'hFFFF_FFFF;
    hreset = 1'b1;
    @(posedge hclk); #1;
    hreset = 1'b0;
    @(negedge hclk);
    checks++;
    if (hreadyout[1] !== 1'b1) begin
      errors++; $display("FAIL rst_wait_hreadyout got=%b exp=1", hreadyout[1]);
    end
    checks++;
    if (hresp[1] !== 1'b0) begin
      errors++; $display("FAIL rst_wait_hresp got=%b exp=0", hresp[1]);
    end
    add(0, 32'h80, 3'b010, 32'h0, 0);
    run_seq(1);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      hsel[d] = 1'b0; haddr[d] = 32'h0; htrans[d] = 2'b00;
      hwrite[d] = 1'b0; hsize[d] = 3'b010; hwdata[d] = 32'h0;
      pend[d] = 1'b0; wc[d] = 0;
    end
    hreset = 1'b1;
    test_reset();
    test_word_rw();
    test_lanes();
    test_wait_states();
    test_errors();
    test_back_to_back();
    test_reset_in_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
